// File: rtl/kgp_loader_pkg.sv
// Shared types and constants for the KGP_RISC byte-stream program loader.
// Imported by the word assembler and the loader top.
package kgp_loader_pkg;

  localparam int WORD_W = 32;
  localparam int BYTES_PER_WORD = WORD_W / 8;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } state_t;

  // Big-endian placement: byte index 0 lands in bits 31:24.
  function automatic logic [WORD_W-1:0] insert_byte(
    input logic [WORD_W-1:0] word,
    input logic [1:0]        idx,
    input logic [7:0]        data
  );
    logic [WORD_W-1:0] result;
    result = word;
    case (idx)
      2'd0:    result[31:24] = data;
      2'd1:    result[23:16] = data;
      2'd2:    result[15:8]  = data;
      default: result[7:0]   = data;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/kgp_word_assembler.sv
// Collects four bytes MSB-first into a 32-bit word; flags the 4th byte so the
// caller can capture the completed word in the same cycle.
module kgp_word_assembler
  import kgp_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word_next,
  output logic              word_ready
);

  logic [1:0]        idx_q;
  logic [WORD_W-1:0] word_q;

  assign word_next  = insert_byte(word_q, idx_q, byte_in);
  assign word_ready = load && (idx_q == 2'(BYTES_PER_WORD - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (clear) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (load) begin
      // Index wraps to 0 after the 4th byte, ready for the next word.
      idx_q  <= idx_q + 2'd1;
      word_q <= word_next;
    end
  end

endmodule

// File: rtl/kgp_program_loader.sv
// Framed byte-stream loader: writes N big-endian words into instruction memory
// from address 0 and holds the core in reset until the whole program is in.
module kgp_program_loader
  import kgp_loader_pkg::*;
#(
  parameter int         ADDR_W    = 10,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error
);

  // Counter is one bit wider than the address so N == 2^ADDR_W terminates
  // without wrapping. Length compares are done at 17 bits (ADDR_W <= 16).
  localparam int          CNT_W     = ADDR_W + 1;
  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  state_t             state_q, state_d;
  logic [15:0]        len_q;
  logic [15:0]        len_full;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_inc;
  logic               last_word;
  logic               accept;
  logic               is_sync;
  logic               asm_load;
  logic               asm_clear;
  logic               word_ready;
  logic [WORD_W-1:0]  word_next;
  logic [ADDR_W-1:0]  imem_addr_q;
  logic [WORD_W-1:0]  imem_wdata_q;

  assign accept    = rx_valid && rx_ready;
  assign is_sync   = (rx_data == SYNC_BYTE);
  assign len_full  = {len_q[15:8], rx_data};
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign last_word = (17'(cnt_inc) == {1'b0, len_q});

  // Kept outside the FSM process so word_ready feeds back without a comb loop.
  assign asm_load  = accept && (state_q == ST_DATA);
  assign asm_clear = accept && (state_q == ST_LEN_LO);

  kgp_word_assembler u_assembler (
    .clk        (clk),
    .reset      (reset),
    .clear      (asm_clear),
    .load       (asm_load),
    .byte_in    (rx_data),
    .word_next  (word_next),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: next-state defaults to the current state before the case so no
  // path leaves state_d unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SYNC: begin
        if (accept && is_sync) state_d = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (accept) state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (accept) begin
          if (len_full == 16'd0) begin
            state_d = ST_DONE;
          end else if ({1'b0, len_full} > MAX_WORDS) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (word_ready) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        state_d = last_word ? ST_DONE : ST_DATA;
      end
      ST_DONE, ST_ERROR: begin
        if (accept && is_sync) state_d = ST_LEN_HI;
      end
      default: state_d = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q        <= '0;
      cnt_q        <= '0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
    end else begin
      if (accept && (state_q == ST_LEN_HI)) len_q[15:8] <= rx_data;
      if (accept && (state_q == ST_LEN_LO)) begin
        len_q[7:0] <= rx_data;
        cnt_q      <= '0;
      end
      // Address and data are captured with the 4th byte and then held, so the
      // memory sees stable values for the whole write cycle and after it.
      if (word_ready) begin
        imem_addr_q  <= cnt_q[ADDR_W-1:0];
        imem_wdata_q <= word_next;
      end
      if (state_q == ST_WRITE) cnt_q <= cnt_inc;
    end
  end

  assign rx_ready   = (state_q != ST_WRITE);
  assign imem_we    = (state_q == ST_WRITE);
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_reset  = (state_q != ST_DONE);
  assign load_done  = (state_q == ST_DONE);
  assign load_error = (state_q == ST_ERROR);

endmodule

// File: tb/tb_kgp_program_loader.sv
// Scoreboard bench for kgp_program_loader: stimulus queues expected writes,
// a negedge monitor pops and compares each imem_we pulse.
module tb_kgp_program_loader;

  localparam int ADDR_W = 10;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [31:0]       cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              load_done;
  logic              load_error;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          writes_seen = 0;
  logic [31:0] cyc = '0;
  logic [31:0] acc_cyc;

  kgp_program_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the head of the scoreboard, arrive in the
  // cycle right after the 4th byte, and happen with the core held in reset.
  always @(negedge clk) begin : monitor
    exp_t e;
    check("rx_ready_vs_we", {31'd0, rx_ready}, {31'd0, !imem_we});
    if (imem_we === 1'b1) begin
      writes_seen++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h expected=none", imem_addr, imem_wdata);
      end else begin
        e = sb_q.pop_front();
        check("wr_addr", 32'(imem_addr), 32'(e.addr));
        check("wr_data", imem_wdata, e.data);
        check("wr_latency", cyc, e.cyc);
        check("wr_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one byte and holds it until accepted; acc_cyc records the edge.
  task automatic send_byte(input logic [7:0] b, input int gap_max);
    logic acc;
    int   waited;
    if (gap_max > 0) idle($urandom_range(0, gap_max));
    rx_data  = b;
    rx_valid = 1'b1;
    acc      = 1'b0;
    waited   = 0;
    while (!acc && waited < 20) begin
      acc = rx_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    rx_valid = 1'b0;
    acc_cyc  = cyc;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout actual=%h expected=accepted", b);
    end
  endtask

  task automatic send_word(input logic [ADDR_W-1:0] addr, input logic [31:0] w, input int gap_max);
    exp_t e;
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], gap_max);
    e.addr = addr;
    e.data = w;
    e.cyc  = acc_cyc;
    sb_q.push_back(e);
  endtask

  task automatic send_header(input logic [15:0] n);
    send_byte(8'hA5, 0);
    send_byte(n[15:8], 0);
    send_byte(n[7:0], 0);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    do_reset();

    // Reset state.
    check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("rst_load_done", {31'd0, load_done}, 32'd0);
    check("rst_load_error", {31'd0, load_error}, 32'd0);
    check("rst_imem_we", {31'd0, imem_we}, 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);

    // Single word frame.
    send_header(16'd1);
    send_word(10'd0, 32'hDEADBEEF, 0);
    idle(2);
    check("t1_load_done", {31'd0, load_done}, 32'd1);
    check("t1_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    check("t1_wdata_hold", imem_wdata, 32'hDEADBEEF);

    // Garbage in SYNC is discarded, then a two-word frame.
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_byte(8'h12, 0);
    check("t2_garbage_done", {31'd0, load_done}, 32'd0);
    send_header(16'd2);
    send_word(10'd0, 32'h11121314, 0);
    send_word(10'd1, 32'h15161718, 0);
    idle(2);
    check("t2_load_done", {31'd0, load_done}, 32'd1);

    // Zero-length frame from DONE: restart then DONE right away.
    send_byte(8'hA5, 0);
    check("t3_restart_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("t3_restart_done", {31'd0, load_done}, 32'd0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("t3_zero_done", {31'd0, load_done}, 32'd1);
    check("t3_zero_cpu_reset", {31'd0, cpu_reset}, 32'd0);

    // Over-length frame (1025 words) goes to ERROR; a sync byte recovers.
    send_header(16'h0401);
    check("t4_error", {31'd0, load_error}, 32'd1);
    check("t4_err_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("t4_err_done", {31'd0, load_done}, 32'd0);
    idle(2);
    send_byte(8'h00, 0);
    check("t4_err_discard", {31'd0, load_error}, 32'd1);
    send_byte(8'hA5, 0);
    check("t4_error_cleared", {31'd0, load_error}, 32'd0);
    check("t4_clr_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_word(10'd0, 32'hC0FFEE00, 0);
    idle(2);
    check("t4_load_done", {31'd0, load_done}, 32'd1);

    // Random rx_valid gaps, sync bytes inside data, back-to-back into WRITE.
    send_header(16'd2);
    send_word(10'd0, 32'hA5012345, 2);
    send_word(10'd1, 32'h6789ABA5, 2);
    idle(2);
    check("t5_load_done", {31'd0, load_done}, 32'd1);

    // Reset mid-DATA drops the partial word; a fresh frame starts at 0.
    send_header(16'd1);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    do_reset();
    check("t6_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("t6_imem_we", {31'd0, imem_we}, 32'd0);
    check("t6_load_done", {31'd0, load_done}, 32'd0);
    check("t6_imem_wdata", imem_wdata, 32'd0);
    send_header(16'd1);
    send_word(10'd0, 32'hCAFEBABE, 0);
    idle(2);
    check("t6_load_done_after", {31'd0, load_done}, 32'd1);

    // Full-depth frame: N == 1024 is legal and ends at address 1023.
    send_header(16'h0400);
    for (int i = 0; i < 1024; i++) send_word(ADDR_W'(i), 32'h5A000000 | 32'(i), 0);
    idle(2);
    check("t7_load_done", {31'd0, load_done}, 32'd1);
    check("t7_load_error", {31'd0, load_error}, 32'd0);
    check("t7_last_addr", 32'(imem_addr), 32'd1023);

    idle(3);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    check("total_writes", 32'(writes_seen), 32'd1031);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kgp_program_loader.md
Name: kgp_program_loader

Overview:
- Byte-stream program loader. It writes a program into the KGP_RISC instruction memory and holds the core in reset while loading.
- Accepts framed bytes over a valid/ready interface, assembles big-endian 32-bit instruction words, and writes them sequentially from address 0.
- Releases cpu_reset once the final word is written. It is the writer side of the memory the core fetches from.

Parameters:
- ADDR_W, 10, instruction-memory word-address width; memory depth is 2^ADDR_W words.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- rx_data  input  8  incoming byte
- rx_valid  input  1  rx_data valid this cycle
- rx_ready  output  1  loader can accept a byte; a transfer happens when rx_valid && rx_ready
- imem_we  output  1  instruction-memory write strobe, one cycle per word
- imem_addr  output  ADDR_W  word address for the write
- imem_wdata  output  32  instruction word
- cpu_reset  output  1  holds the core in reset; high while not in DONE
- load_done  output  1  level, high in DONE
- load_error  output  1  level, high in ERROR

Behaviour:
- Reset values: state=SYNC, cpu_reset=1, imem_we=0, imem_addr=0, imem_wdata=0, load_done=0, load_error=0, word counter=0, byte index=0.
- Frame format: SYNC_BYTE, LEN_HI, LEN_LO (16-bit word count N), then N*4 data bytes, MSB first per word.
- rx_ready is high in every state except WRITE.
- SYNC:
  - Accepted byte == SYNC_BYTE -> LEN_HI.
  - Any other byte is discarded.
- LEN_HI: latch N[15:8] -> LEN_LO.
- LEN_LO: latch N[7:0], then:
  - N == 0 -> DONE.
  - N > 2^ADDR_W -> ERROR.
  - Otherwise -> DATA, with word counter=0 and byte index=0.
- DATA:
  - Each accepted byte shifts into the word register at the position for byte index (0 = bits 31:24).
  - On the 4th byte -> WRITE.
- WRITE (exactly one cycle):
  - imem_we=1, imem_addr=word counter, imem_wdata=assembled word.
  - Next cycle: counter+1, byte index=0. Counter+1 == N -> DONE; else -> DATA.
  - Latency is one cycle from accepting the 4th byte to the imem_we pulse.
- DONE:
  - cpu_reset=0, load_done=1.
  - An accepted SYNC_BYTE restarts the load: -> LEN_HI, cpu_reset=1 and load_done=0 on the next cycle.
  - Any other byte is discarded.
- ERROR:
  - cpu_reset=1, load_error=1, no memory writes.
  - An accepted SYNC_BYTE -> LEN_HI and clears load_error.
- imem_we is 0 in all states except WRITE. imem_addr and imem_wdata hold their last values outside WRITE.
- N == 2^ADDR_W is legal: the final write goes to address 2^ADDR_W-1, and the counter width is ADDR_W+1 so it does not wrap.
- rx_valid low in any state: nothing happens. Partially assembled words persist indefinitely.
- reset asserted mid-frame: returns to SYNC with all reset values next cycle. Any partial word is dropped and words already written stay in memory.
- A byte equal to SYNC_BYTE inside LEN or DATA is treated as data, not as resync.

Decomposition:
- Shared package kgp_loader_pkg:
  - state enum: SYNC, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERROR.
  - SYNC_BYTE default.
  - WORD_W=32.
- One sub-module, kgp_word_assembler: byte-index counter and 32-bit shift register with load/clear. It outputs word_ready when the 4th byte is accepted.
- FSM, counters and port logic stay in the top.

Test Plan:
- Reset then A5 00 01 DE AD BE EF -> one imem_we pulse with addr=0, data=32'hDEADBEEF, one cycle after the EF byte; then load_done=1, cpu_reset=0.
- Garbage 00 FF 12, then A5 00 02 and 8 bytes 11..18 -> writes 32'h11121314 at addr 0 and 32'h15161718 at addr 1; garbage causes no writes; rx_ready=0 only in the WRITE cycles.
- A5 00 00 -> DONE immediately, zero writes. With ADDR_W=10, A5 04 01 -> load_error=1, cpu_reset=1, no writes; a following A5 clears load_error.
- A 2-word frame with rx_valid toggling randomly, including rx_valid=1 during the WRITE cycle -> no byte lost or duplicated; the held byte is accepted the cycle after WRITE and the words are exact.
- Mid-DATA reset after 2 bytes -> SYNC, cpu_reset=1, imem_we=0. A fresh 1-word frame then writes addr 0 correctly. From DONE, A5 00 01 + 4 bytes -> cpu_reset reasserted for the whole reload and addr restarts at 0.
